// File: rtl/ui_uart_rx_if.sv
// rtl/ui_uart_rx_if.sv - serial line, baud tick and received-byte signals of the UART receiver
interface ui_uart_rx_if;
    logic       baud_x16_en;
    logic       rxd_pin;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       frm_err;

    modport master (
        input  baud_x16_en,
        input  rxd_pin,
        output rx_data,
        output rx_data_rdy,
        output frm_err
    );

    modport slave (
        output baud_x16_en,
        output rxd_pin,
        input  rx_data,
        input  rx_data_rdy,
        input  frm_err
    );
endinterface

// File: rtl/ui_uart_rx.sv
// rtl/ui_uart_rx.sv - 8N1 UART receiver, 16x oversampled, mid-bit sampling, framing-error detect
module ui_uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    ui_uart_rx_if.master    bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] warm_q;
    logic                   rxd_s;
    logic                   settled;
    logic                   armed;
    logic [3:0]             cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic [7:0]             rx_data_q;
    logic                   rx_data_rdy_q;
    logic                   frm_err_q;

    assign rxd_s   = sync_q[SYNC_STAGES-1];
    assign settled = warm_q[SYNC_STAGES-1];

    // warm_q marks when the synchronizer holds real line samples rather than its reset ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rxd_pin};
            warm_q <= {warm_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // armed requires a high line after reset so a frame cut by reset is not re-entered mid-byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            bit_idx       <= 3'd0;
            shreg         <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_data_rdy_q <= 1'b0;
            frm_err_q     <= 1'b0;
            armed         <= 1'b0;
        end else begin
            rx_data_rdy_q <= 1'b0;
            frm_err_q     <= 1'b0;
            if (bus.baud_x16_en) begin
                case (state)
                    IDLE: begin
                        if (!rxd_s && armed) begin
                            state <= START;
                            cnt   <= 4'd0;
                        end else if (rxd_s && settled) begin
                            armed <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            if (!rxd_s) begin
                                state   <= DATA;
                                bit_idx <= 3'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                    DATA: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            shreg   <= {rxd_s, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                                cnt   <= 4'd0;
                            end
                        end
                    end
                    STOP: begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            if (rxd_s) begin
                                rx_data_q     <= shreg;
                                rx_data_rdy_q <= 1'b1;
                                state         <= IDLE;
                            end else begin
                                frm_err_q <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxd_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_data_rdy = rx_data_rdy_q;
    assign bus.frm_err     = frm_err_q;

endmodule

// File: doc/ui_uart_rx.md
UI_UART_RX -- requirements
Module: ui_uart_rx

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flops in the rxd metastability synchronizer (minimum 2).
REQ-002 Port: clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: baud_x16_en  input  1  one-clk enable pulse at 16x the baud rate, produced by ui_uart_baud_gen.
REQ-005 Port: rxd_pin  input  1  asynchronous serial line; idle high; format 8N1, LSB first.
REQ-006 Port: rx_data  output  8  last correctly framed received byte.
REQ-007 Port: rx_data_rdy  output  1  one-clk pulse; rx_data is valid and newly updated.
REQ-008 Port: frm_err  output  1  one-clk pulse; stop bit was sampled low.

Function
REQ-009 rxd_pin SHALL pass through a SYNC_STAGES-deep flop chain before use; the synchronized signal is rxd_s.
REQ-010 All FSM state changes, counter changes and rxd_s sampling SHALL occur only in clocks where baud_x16_en=1; in all other clocks, state holds.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-012 The oversample counter SHALL be 4 bits and wrap 15->0; the bit index SHALL be 3 bits (0..7).
REQ-013 IDLE: on a tick with rxd_s=0 -> START, counter<=0.
REQ-014 START: counter increments each tick; on the tick where counter=7 (mid start bit): rxd_s=0 -> DATA, counter<=0, bit index<=0; rxd_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: on the tick where counter=15, rxd_s SHALL be shifted into the shift register MSB so the first bit lands at bit 0 after 8 shifts; bit index increments; after bit index 7 is sampled -> STOP, counter<=0.
REQ-016 STOP: on the tick where counter=15, rxd_s is sampled.
REQ-017 Stop sampled 1: rx_data<=shift register and rx_data_rdy=1 for the following clock only; -> IDLE.
REQ-018 Stop sampled 0: frm_err=1 for the following clock only; rx_data unchanged; rx_data_rdy stays 0; -> WAIT_HIGH.
REQ-019 WAIT_HIGH: on a tick with rxd_s=1 -> IDLE; a held-low line (break) SHALL NOT start new frames.
REQ-020 rx_data_rdy and frm_err SHALL be registered outputs, never asserted together, and never asserted for more than one clk.
REQ-021 Sampling point for data bit n SHALL be 24+16n ticks after the tick on which the start edge was detected (mid-bit).
REQ-022 A start bit detected in IDLE on the tick immediately after a valid stop SHALL be accepted (back-to-back frames, no idle gap).
REQ-023 rx_data SHALL hold its value between frames and across glitch rejections.

Reset
REQ-024 With rst=1 at a clock edge: FSM<=IDLE, counter<=0, bit index<=0, shift register<=0x00, rx_data<=0x00, rx_data_rdy<=0, frm_err<=0, synchronizer flops<=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no rx_data_rdy or frm_err pulse; reception resumes on the next start edge after rst deasserts.

Verification
REQ-026 Send 0xA5, 8N1, with 16 ticks/bit -> exactly one rx_data_rdy pulse, rx_data=0xA5, frm_err never asserted.
REQ-027 Drive rxd_pin low for 4 ticks then high -> FSM returns to IDLE; no rx_data_rdy or frm_err pulse; rx_data unchanged.
REQ-028 Send 0x3C with the stop bit low, then hold low for 40 ticks, then high, then send 0x5A -> one frm_err pulse, rx_data stays at its prior value, no frame while low, then rx_data_rdy with rx_data=0x5A.
REQ-029 Send 0x00 then 0xFF back-to-back with no idle gap -> two rx_data_rdy pulses, with rx_data=0x00 then 0xFF.
REQ-030 Assert rst for 1 clk during data bit 3 of 0x81, then send 0x42 -> no pulse for the aborted frame; one rx_data_rdy with rx_data=0x42.
REQ-031 Hold baud_x16_en=1 every clock and send 0x96 at 16 clk/bit -> rx_data=0x96; each pulse is exactly 1 clk wide.
